// File: rtl/simple_rx_checker.sv
// simple_rx_checker: AXI4-Stream sink that checks the fixed 2-beat loopback test packet
// beat by beat and keeps good-packet, bad-packet and accepted-beat counters.
module simple_rx_checker #(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter logic [C_S_AXIS_DATA_WIDTH-1:0] C_EXP_DATA0 =
    256'h00000007_00090000_00060001_00000000_02000888_bbbbbbbb_bbbbaaaa_aaaaaaaa,
  parameter logic [C_S_AXIS_TUSER_WIDTH-1:0] C_EXP_TUSER0 = 128'h04800040,
  parameter logic [C_S_AXIS_DATA_WIDTH-1:0] C_EXP_DATA1 =
    256'hdddddddddddddccccccccccaaaaaaaaaaaffffffeeeee,
  parameter int C_CNT_WIDTH = 32
) (
  input  logic                              S_AXIS_ACLK,
  input  logic                              S_AXIS_ARESET,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    S_AXIS_TDATA,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  S_AXIS_TSTRB,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   S_AXIS_TUSER,
  input  logic                              S_AXIS_TVALID,
  output logic                              S_AXIS_TREADY,
  input  logic                              S_AXIS_TLAST,
  input  logic                              rx_stall,
  input  logic                              rst_cntrs,
  output logic [C_CNT_WIDTH-1:0]            pkt_ok_count,
  output logic [C_CNT_WIDTH-1:0]            pkt_err_count,
  output logic [C_CNT_WIDTH-1:0]            beat_count,
  output logic                              pkt_done,
  output logic                              pkt_err,
  output logic [1:0]                        last_err_code
);

  localparam logic [C_CNT_WIDTH-1:0] CNT_ONE = 1;

  localparam logic [1:0] CODE_MISMATCH = 2'd1;
  localparam logic [1:0] CODE_SHORT    = 2'd2;
  localparam logic [1:0] CODE_LONG     = 2'd3;

  typedef enum logic [1:0] {
    HEAD  = 2'd0,
    TAIL  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;
  logic       hdr_err;
  logic       hdr_err_next;
  logic       handshake;
  logic       strb_ok;
  logic       head_match;
  logic       tail_match;
  logic       done_next;
  logic       err_next;
  logic       ok_inc;
  logic       err_inc;
  logic       code_set;
  logic [1:0] code_val;

  assign handshake  = S_AXIS_TVALID & S_AXIS_TREADY;
  assign strb_ok    = (S_AXIS_TSTRB == '1);
  assign head_match = (S_AXIS_TDATA == C_EXP_DATA0) && strb_ok && (S_AXIS_TUSER == C_EXP_TUSER0);
  assign tail_match = (S_AXIS_TDATA == C_EXP_DATA1) && strb_ok && (S_AXIS_TUSER == '0);

  // Packet-walk decode: next state, header-error flag, completion pulse and counter strobes
  always_comb begin
    state_next   = state;
    hdr_err_next = hdr_err;
    done_next    = 1'b0;
    err_next     = 1'b0;
    ok_inc       = 1'b0;
    err_inc      = 1'b0;
    code_set     = 1'b0;
    code_val     = 2'd0;
    case (state)
      HEAD: begin
        if (handshake) begin
          if (S_AXIS_TLAST) begin
            done_next = 1'b1;
            err_next  = 1'b1;
            err_inc   = 1'b1;
            code_set  = 1'b1;
            code_val  = CODE_SHORT;
          end else begin
            hdr_err_next = ~head_match;
            state_next   = TAIL;
          end
        end
      end
      TAIL: begin
        if (handshake) begin
          if (S_AXIS_TLAST) begin
            done_next  = 1'b1;
            state_next = HEAD;
            if (hdr_err || !tail_match) begin
              err_next = 1'b1;
              err_inc  = 1'b1;
              code_set = 1'b1;
              code_val = CODE_MISMATCH;
            end else begin
              ok_inc = 1'b1;
            end
          end else begin
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (handshake && S_AXIS_TLAST) begin
          done_next  = 1'b1;
          err_next   = 1'b1;
          err_inc    = 1'b1;
          code_set   = 1'b1;
          code_val   = CODE_LONG;
          state_next = HEAD;
        end
      end
      default: begin
        state_next = HEAD;
      end
    endcase
  end

  // FSM state and per-packet header-error flag; reset abandons any packet in flight
  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET) begin
      state   <= HEAD;
      hdr_err <= 1'b0;
    end else begin
      state   <= state_next;
      hdr_err <= hdr_err_next;
    end
  end

  // TREADY is purely registered from the stall input, never from TVALID
  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET) begin
      S_AXIS_TREADY <= 1'b0;
    end else begin
      S_AXIS_TREADY <= ~rx_stall;
    end
  end

  // Wrapping counters and sticky error code; a counter clear beats a same-cycle increment
  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET || rst_cntrs) begin
      pkt_ok_count  <= '0;
      pkt_err_count <= '0;
      beat_count    <= '0;
      last_err_code <= 2'd0;
    end else begin
      if (ok_inc) begin
        pkt_ok_count <= pkt_ok_count + CNT_ONE;
      end
      if (err_inc) begin
        pkt_err_count <= pkt_err_count + CNT_ONE;
      end
      if (handshake) begin
        beat_count <= beat_count + CNT_ONE;
      end
      if (code_set) begin
        last_err_code <= code_val;
      end
    end
  end

  // Completion pulse and its error qualifier, one clock after the final handshake
  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET) begin
      pkt_done <= 1'b0;
      pkt_err  <= 1'b0;
    end else begin
      pkt_done <= done_next;
      pkt_err  <= err_next;
    end
  end

endmodule

// File: tb/tb_simple_rx_checker.sv
// tb_simple_rx_checker: directed stimulus for simple_rx_checker with hand-computed
// expectations checked through immediate assertions.
module tb_simple_rx_checker;

  localparam logic [255:0] EXP_D0 =
    256'h00000007_00090000_00060001_00000000_02000888_bbbbbbbb_bbbbaaaa_aaaaaaaa;
  localparam logic [255:0] EXP_D1 =
    256'hdddddddddddddccccccccccaaaaaaaaaaaffffffeeeee;
  localparam logic [127:0] EXP_U0   = 128'h04800040;
  localparam logic [31:0]  ALL_STRB = 32'hFFFF_FFFF;

  logic         clk = 1'b0;
  logic         areset;
  logic [255:0] tdata;
  logic [31:0]  tstrb;
  logic [127:0] tuser;
  logic         tvalid;
  logic         tready;
  logic         tlast;
  logic         rx_stall;
  logic         rst_cntrs;
  logic [31:0]  pkt_ok_count;
  logic [31:0]  pkt_err_count;
  logic [31:0]  beat_count;
  logic         pkt_done;
  logic         pkt_err;
  logic [1:0]   last_err_code;

  int check_count = 0;
  int pass_count  = 0;

  simple_rx_checker dut (
    .S_AXIS_ACLK   (clk),
    .S_AXIS_ARESET (areset),
    .S_AXIS_TDATA  (tdata),
    .S_AXIS_TSTRB  (tstrb),
    .S_AXIS_TUSER  (tuser),
    .S_AXIS_TVALID (tvalid),
    .S_AXIS_TREADY (tready),
    .S_AXIS_TLAST  (tlast),
    .rx_stall      (rx_stall),
    .rst_cntrs     (rst_cntrs),
    .pkt_ok_count  (pkt_ok_count),
    .pkt_err_count (pkt_err_count),
    .beat_count    (beat_count),
    .pkt_done      (pkt_done),
    .pkt_err       (pkt_err),
    .last_err_code (last_err_code)
  );

  // 100 MHz free-running clock
  always #5 clk = ~clk;

  // Safety net so a stuck run still ends
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  // Present one beat and hold it until accepted; returns 1 ns after the accepting edge
  task automatic applyStimulus(input logic [255:0] data, input logic [31:0] strb,
                               input logic [127:0] user, input logic last);
    logic got;
    got    = 1'b0;
    tvalid = 1'b1;
    tdata  = data;
    tstrb  = strb;
    tuser  = user;
    tlast  = last;
    for (int i = 0; i < 20 && !got; i++) begin
      got = tready;
      @(posedge clk);
      #1;
    end
    checkOutput("handshake", {63'b0, got}, 64'd1);
  endtask

  task automatic sendGoodPacket();
    applyStimulus(EXP_D0, ALL_STRB, EXP_U0, 1'b0);
    applyStimulus(EXP_D1, ALL_STRB, '0, 1'b1);
  endtask

  task automatic clearCounters();
    tvalid    = 1'b0;
    rst_cntrs = 1'b1;
    @(posedge clk);
    #1;
    rst_cntrs = 1'b0;
  endtask

  // Directed scenario sequence
  initial begin
    logic [255:0] bad_d0;
    areset    = 1'b1;
    tvalid    = 1'b0;
    tdata     = '0;
    tstrb     = '0;
    tuser     = '0;
    tlast     = 1'b0;
    rx_stall  = 1'b0;
    rst_cntrs = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_tready", tready, 0);
    checkOutput("rst_ok", pkt_ok_count, 0);
    checkOutput("rst_err", pkt_err_count, 0);
    checkOutput("rst_beats", beat_count, 0);
    checkOutput("rst_done", pkt_done, 0);
    checkOutput("rst_pkt_err", pkt_err, 0);
    checkOutput("rst_code", last_err_code, 0);
    areset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("tready_after_reset", tready, 1);

    $display("[TB] scenario 1: four back-to-back good packets");
    for (int p = 0; p < 4; p++) begin
      sendGoodPacket();
      checkOutput("s1_done", pkt_done, 1);
      checkOutput("s1_pkt_err", pkt_err, 0);
    end
    tvalid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("s1_done_pulse_ends", pkt_done, 0);
    checkOutput("s1_ok", pkt_ok_count, 4);
    checkOutput("s1_err", pkt_err_count, 0);
    checkOutput("s1_beats", beat_count, 8);

    $display("[TB] scenario 2: corrupted header, then mismatches on beat 1");
    clearCounters();
    checkOutput("s2_clear_beats", beat_count, 0);
    checkOutput("s2_clear_ok", pkt_ok_count, 0);
    bad_d0 = EXP_D0 ^ 256'd1;
    applyStimulus(bad_d0, ALL_STRB, EXP_U0, 1'b0);
    applyStimulus(EXP_D1, ALL_STRB, '0, 1'b1);
    checkOutput("s2_done", pkt_done, 1);
    checkOutput("s2_pkt_err", pkt_err, 1);
    checkOutput("s2_err", pkt_err_count, 1);
    checkOutput("s2_ok", pkt_ok_count, 0);
    checkOutput("s2_code", last_err_code, 1);
    sendGoodPacket();
    checkOutput("s2_good_pkt_err", pkt_err, 0);
    checkOutput("s2_good_ok", pkt_ok_count, 1);
    checkOutput("s2_code_sticky", last_err_code, 1);
    applyStimulus(EXP_D0, ALL_STRB, EXP_U0, 1'b0);
    applyStimulus(EXP_D1, ALL_STRB, 128'd1, 1'b1);
    checkOutput("s2_tuser1_pkt_err", pkt_err, 1);
    checkOutput("s2_tuser1_err", pkt_err_count, 2);
    applyStimulus(EXP_D0, ALL_STRB, EXP_U0, 1'b0);
    applyStimulus(EXP_D1, 32'h7FFF_FFFF, '0, 1'b1);
    checkOutput("s2_strb_pkt_err", pkt_err, 1);
    checkOutput("s2_strb_err", pkt_err_count, 3);
    checkOutput("s2_beats", beat_count, 8);

    $display("[TB] scenario 3: short packet then long packet");
    clearCounters();
    applyStimulus(EXP_D0, ALL_STRB, EXP_U0, 1'b1);
    checkOutput("s3_short_done", pkt_done, 1);
    checkOutput("s3_short_pkt_err", pkt_err, 1);
    checkOutput("s3_short_code", last_err_code, 2);
    checkOutput("s3_short_err", pkt_err_count, 1);
    applyStimulus(EXP_D0, ALL_STRB, EXP_U0, 1'b0);
    applyStimulus(EXP_D1, ALL_STRB, '0, 1'b0);
    checkOutput("s3_no_done_mid_long", pkt_done, 0);
    applyStimulus(EXP_D1, ALL_STRB, '0, 1'b1);
    checkOutput("s3_long_done", pkt_done, 1);
    checkOutput("s3_long_pkt_err", pkt_err, 1);
    checkOutput("s3_err", pkt_err_count, 2);
    checkOutput("s3_code", last_err_code, 3);
    checkOutput("s3_beats", beat_count, 4);
    checkOutput("s3_ok", pkt_ok_count, 0);
    sendGoodPacket();
    checkOutput("s3_head_good_pkt_err", pkt_err, 0);
    checkOutput("s3_head_good_ok", pkt_ok_count, 1);
    tvalid = 1'b0;

    $display("[TB] scenario 4: stall toggling during two good packets");
    clearCounters();
    fork
      begin
        sendGoodPacket();
        checkOutput("s4_done_a", pkt_done, 1);
        checkOutput("s4_pkt_err_a", pkt_err, 0);
        sendGoodPacket();
        tvalid = 1'b0;
        checkOutput("s4_done_b", pkt_done, 1);
        checkOutput("s4_pkt_err_b", pkt_err, 0);
      end
      begin
        for (int i = 0; i < 16; i++) begin
          @(posedge clk);
          #1;
          checkOutput("s4_tready_lag", {63'b0, tready}, {63'b0, ~rx_stall});
          rx_stall = ~rx_stall;
        end
        rx_stall = 1'b0;
      end
    join
    repeat (2) @(posedge clk);
    #1;
    checkOutput("s4_ok", pkt_ok_count, 2);
    checkOutput("s4_err", pkt_err_count, 0);
    checkOutput("s4_beats", beat_count, 4);
    checkOutput("s4_tready_restored", tready, 1);

    $display("[TB] scenario 5: counter clear coinciding with tail handshake");
    applyStimulus(EXP_D0, ALL_STRB, EXP_U0, 1'b1);
    checkOutput("s5_pre_err", pkt_err_count, 1);
    checkOutput("s5_pre_code", last_err_code, 2);
    applyStimulus(EXP_D0, ALL_STRB, EXP_U0, 1'b0);
    rst_cntrs = 1'b1;
    applyStimulus(EXP_D1, ALL_STRB, '0, 1'b1);
    rst_cntrs = 1'b0;
    tvalid    = 1'b0;
    checkOutput("s5_ok", pkt_ok_count, 0);
    checkOutput("s5_err", pkt_err_count, 0);
    checkOutput("s5_beats", beat_count, 0);
    checkOutput("s5_code", last_err_code, 0);
    checkOutput("s5_done", pkt_done, 1);
    checkOutput("s5_pkt_err", pkt_err, 0);

    $display("[TB] scenario 6: reset after header beat, then a good packet");
    applyStimulus(EXP_D0, ALL_STRB, EXP_U0, 1'b0);
    tvalid = 1'b0;
    checkOutput("s6_beat_before_reset", beat_count, 1);
    areset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("s6_tready_in_reset", tready, 0);
    checkOutput("s6_beats_in_reset", beat_count, 0);
    @(posedge clk);
    #1;
    checkOutput("s6_tready_in_reset_2", tready, 0);
    areset = 1'b0;
    sendGoodPacket();
    tvalid = 1'b0;
    checkOutput("s6_done", pkt_done, 1);
    checkOutput("s6_pkt_err", pkt_err, 0);
    checkOutput("s6_ok", pkt_ok_count, 1);
    checkOutput("s6_err", pkt_err_count, 0);
    checkOutput("s6_beats", beat_count, 2);

    @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
